// File: rtl/cache_pkg.sv
// Shared types and defaults for the cache sequencing controller.
package cache_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int STAT_W_DEF = 16;

  localparam logic DIR_RD = 1'b0;
  localparam logic DIR_WR = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    COMPARE,
    WRITEBACK,
    ALLOCATE,
    RESP,
    FLUSH,
    FLUSH_ACK
  } state_e;

endpackage

// File: rtl/cache_ctrl_fsm_if.sv
// CPU, datapath and memory signals of the cache controller in one bundle.
interface cache_ctrl_fsm_if
  import cache_pkg::*;
#(
  parameter int ADDRESS_WIDTH = ADDR_W_DEF,
  parameter int DATA_WIDTH    = DATA_W_DEF,
  parameter int STAT_WIDTH    = STAT_W_DEF
);
  logic                     cpu_req_valid;
  logic                     cpu_req_ready;
  logic [ADDRESS_WIDTH-1:0] cpu_addr_in;
  logic [DATA_WIDTH-1:0]    cpu_wdata_in;
  logic                     cpu_rd_wr_in;
  logic                     cpu_resp_valid;
  logic                     cpu_resp_err;
  logic                     flush_req;
  logic                     flush_ack;
  logic [ADDRESS_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0]    cpu_data_in;
  logic                     CPU_rd_wr;
  logic                     cache_enable;
  logic                     cache_writeback;
  logic                     cache_allocate;
  logic                     cache_flush;
  logic                     Cache_hit;
  logic                     Dirty_bit;
  logic                     flush_done;
  logic                     mem_req;
  logic                     mem_we;
  logic                     mem_ready;
  logic [STAT_WIDTH-1:0]    hit_count;
  logic [STAT_WIDTH-1:0]    miss_count;

  // master: the controller; slave: CPU, datapath and memory around it
  modport master (
    input  cpu_req_valid, cpu_addr_in, cpu_wdata_in, cpu_rd_wr_in, flush_req,
           Cache_hit, Dirty_bit, flush_done, mem_ready,
    output cpu_req_ready, cpu_resp_valid, cpu_resp_err, flush_ack, cpu_addr,
           cpu_data_in, CPU_rd_wr, cache_enable, cache_writeback, cache_allocate,
           cache_flush, mem_req, mem_we, hit_count, miss_count
  );

  modport slave (
    output cpu_req_valid, cpu_addr_in, cpu_wdata_in, cpu_rd_wr_in, flush_req,
           Cache_hit, Dirty_bit, flush_done, mem_ready,
    input  cpu_req_ready, cpu_resp_valid, cpu_resp_err, flush_ack, cpu_addr,
           cpu_data_in, CPU_rd_wr, cache_enable, cache_writeback, cache_allocate,
           cache_flush, mem_req, mem_we, hit_count, miss_count
  );
endinterface

// File: rtl/cache_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module cache_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                       count <= '0;
    else if (clr)                   count <= '0;
    else if (inc && (count != '1))  count <= count + WIDTH'(1);
  end
endmodule

// File: rtl/cache_ctrl_fsm.sv
// Sequencing controller for a direct-mapped cache: hit/miss handling,
// write-back/refill memory handshake with timeout, flush arbitration, stats.
module cache_ctrl_fsm
  import cache_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = ADDR_W_DEF,
  parameter int DATA_WIDTH     = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int STAT_WIDTH     = STAT_W_DEF
) (
  input logic              clk,
  input logic              rst,
  cache_ctrl_fsm_if.master bus
);
  localparam int            TW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_e                   state, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]    data_q;
  logic                     dir_q;
  logic                     refilled_q;
  logic [TW-1:0]            tcnt;
  logic                     ready_q, resp_q, err_q, ack_q, flush_q, mem_req_q, mem_we_q;
  logic                     latch, to_err, refill_done, tmo;
  logic                     hit_inc, miss_inc;

  // Timeout fires on the TIMEOUT_CYCLES-th consecutive cycle without mem_ready
  assign tmo = !bus.mem_ready && (tcnt == T_LAST);

  always_comb begin
    state_d     = state;
    latch       = 1'b0;
    to_err      = 1'b0;
    refill_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.flush_req)          state_d = FLUSH;
        else if (bus.cpu_req_valid) begin
          state_d = COMPARE;
          latch   = 1'b1;
        end
      end
      COMPARE: begin
        if (bus.Cache_hit)   state_d = RESP;
        else if (refilled_q) begin
          state_d = RESP;
          to_err  = 1'b1;
        end
        else state_d = bus.Dirty_bit ? WRITEBACK : ALLOCATE;
      end
      WRITEBACK: begin
        if (bus.mem_ready) state_d = ALLOCATE;
        else if (tmo) begin
          state_d = RESP;
          to_err  = 1'b1;
        end
      end
      ALLOCATE: begin
        if (bus.mem_ready) begin
          state_d     = COMPARE;
          refill_done = 1'b1;
        end
        else if (tmo) begin
          state_d = RESP;
          to_err  = 1'b1;
        end
      end
      RESP:      state_d = IDLE;
      FLUSH:     if (bus.flush_done) state_d = FLUSH_ACK;
      FLUSH_ACK: state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Level/handshake outputs are registered as a decode of the next state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      dir_q      <= DIR_RD;
      refilled_q <= 1'b0;
      tcnt       <= '0;
      ready_q    <= 1'b1;
      resp_q     <= 1'b0;
      err_q      <= 1'b0;
      ack_q      <= 1'b0;
      flush_q    <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
    end else begin
      state     <= state_d;
      ready_q   <= (state_d == IDLE);
      resp_q    <= (state_d == RESP);
      err_q     <= (state_d == RESP) && to_err;
      ack_q     <= (state_d == FLUSH_ACK);
      flush_q   <= (state_d == FLUSH);
      mem_req_q <= (state_d == WRITEBACK) || (state_d == ALLOCATE);
      mem_we_q  <= (state_d == WRITEBACK);
      if (latch) begin
        addr_q <= bus.cpu_addr_in;
        data_q <= bus.cpu_wdata_in;
        dir_q  <= bus.cpu_rd_wr_in;
      end
      if (latch)            refilled_q <= 1'b0;
      else if (refill_done) refilled_q <= 1'b1;
      if (state_d != state) tcnt <= '0;
      else if ((state == WRITEBACK) || (state == ALLOCATE)) tcnt <= tcnt + TW'(1);
    end
  end

  assign bus.cpu_req_ready   = ready_q;
  assign bus.cpu_resp_valid  = resp_q;
  assign bus.cpu_resp_err    = err_q;
  assign bus.flush_ack       = ack_q;
  assign bus.cache_flush     = flush_q;
  assign bus.mem_req         = mem_req_q;
  assign bus.mem_we          = mem_we_q;
  assign bus.cpu_addr        = addr_q;
  assign bus.cpu_data_in     = data_q;
  assign bus.CPU_rd_wr       = dir_q;

  // Datapath strobes follow the same-cycle hit / memory completion
  assign bus.cache_enable    = (state == COMPARE)   && bus.Cache_hit;
  assign bus.cache_writeback = (state == WRITEBACK) && bus.mem_ready;
  assign bus.cache_allocate  = (state == ALLOCATE)  && bus.mem_ready;

  // A COMPARE after refill is the completing access, not a new lookup
  assign hit_inc  = (state == COMPARE) && bus.Cache_hit  && !refilled_q;
  assign miss_inc = (state == COMPARE) && !bus.Cache_hit && !refilled_q;

  cache_sat_counter #(.WIDTH(STAT_WIDTH)) u_hit_cnt (
    .clk(clk), .rst(rst), .inc(hit_inc), .clr(1'b0), .count(bus.hit_count)
  );

  cache_sat_counter #(.WIDTH(STAT_WIDTH)) u_miss_cnt (
    .clk(clk), .rst(rst), .inc(miss_inc), .clr(1'b0), .count(bus.miss_count)
  );
endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// Randomized transaction-level bench for cache_ctrl_fsm with a reactive
// datapath/memory environment and a per-transaction outcome model.
module tb_cache_ctrl_fsm;
  import cache_pkg::*;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int TO   = 4;
  localparam int SW   = 4;
  localparam int SMAX = (1 << SW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cache_ctrl_fsm_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .STAT_WIDTH(SW)) bus();

  cache_ctrl_fsm #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO), .STAT_WIDTH(SW)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // environment state for the current transaction
  bit            start, t_fl, t_wr, hit_sel, dirty_sel, viol, refilled, in_mem, cur_we;
  logic [AW-1:0] t_addr;
  logic [DW-1:0] t_data;
  int            wb_lat, al_lat, fl_lat, ph, fc;
  int            cyc, acc_at, resp_at, ack_at;
  bit            resp_seen, resp_err;
  int            n_req, n_we, n_wb, n_al, n_en, n_fl, n_ack;
  int            m_hit, m_miss;

  // One clock: drive environment at negedge, sample 1 time unit later
  task automatic tick();
    @(negedge clk);
    if (start) begin
      start             = 1'b0;
      bus.cpu_addr_in   = t_addr;
      bus.cpu_wdata_in  = t_data;
      bus.cpu_rd_wr_in  = t_wr;
      bus.cpu_req_valid = 1'b1;
      bus.flush_req     = t_fl;
    end else begin
      if (acc_at >= 0)     bus.cpu_req_valid = 1'b0;
      if (bus.cache_flush) bus.flush_req     = 1'b0;
    end
    if (bus.mem_req) begin
      if (!in_mem || (bus.mem_we != cur_we)) ph = 0;
      in_mem        = 1'b1;
      cur_we        = bus.mem_we;
      bus.mem_ready = (ph == (cur_we ? wb_lat : al_lat));
      ph++;
    end else begin
      in_mem        = 1'b0;
      bus.mem_ready = 1'b0;
    end
    if (bus.cache_flush) begin
      bus.flush_done = (fc == fl_lat);
      fc++;
    end else begin
      fc             = 0;
      bus.flush_done = 1'b0;
    end
    bus.Cache_hit = hit_sel | (refilled & ~viol);
    bus.Dirty_bit = dirty_sel & ~refilled;
    #1;
    if (bus.cpu_req_ready && bus.cpu_req_valid && !bus.flush_req && acc_at < 0) acc_at = cyc;
    if (bus.mem_req)                n_req++;
    if (bus.mem_req && bus.mem_we)  n_we++;
    if (bus.cache_writeback)        n_wb++;
    if (bus.cache_allocate)         n_al++;
    if (bus.cache_flush)            n_fl++;
    if (bus.cache_enable) begin
      n_en++;
      chk("en_addr", 32'(bus.cpu_addr), 32'(t_addr));
      chk("en_data", 32'(bus.cpu_data_in), 32'(t_data));
      chk("en_dir",  32'(bus.CPU_rd_wr), 32'(t_wr));
    end
    if (bus.cache_allocate) refilled = 1'b1;
    if (bus.flush_ack) begin
      n_ack++;
      ack_at = cyc;
    end
    if (bus.cpu_resp_valid && !resp_seen) begin
      resp_seen = 1'b1;
      resp_at   = cyc;
      resp_err  = bus.cpu_resp_err;
    end
    cyc++;
  endtask

  task automatic clear_env();
    cyc = 0; acc_at = -1; resp_at = -1; ack_at = -1;
    resp_seen = 1'b0; resp_err = 1'b0; refilled = 1'b0;
    n_req = 0; n_we = 0; n_wb = 0; n_al = 0; n_en = 0; n_fl = 0; n_ack = 0;
  endtask

  task automatic run_txn(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input bit hs, input bit ds, input int wl, input int al,
                         input bit fl, input int fll, input bit vi, input bit cnt_chk);
    int lat, e_req, e_we, e_wb, e_al, e_en;
    bit e_err;
    clear_env();
    t_wr = wr; t_addr = a; t_data = d; t_fl = fl;
    hit_sel = hs; dirty_sel = ds; wb_lat = wl; al_lat = al; fl_lat = fll; viol = vi;
    // expected outcome from the hit/miss/latency rules
    lat = 1; e_req = 0; e_we = 0; e_wb = 0; e_al = 0; e_en = 0; e_err = 1'b0;
    if (hs) begin
      e_en = 1;
      if (m_hit < SMAX) m_hit++;
    end else begin
      if (m_miss < SMAX) m_miss++;
      if (ds) begin
        if (wl >= TO) begin
          e_err = 1'b1; e_req += TO; e_we += TO; lat += TO;
        end else begin
          e_req += wl + 1; e_we += wl + 1; e_wb = 1; lat += wl + 1;
        end
      end
      if (!e_err) begin
        if (al >= TO) begin
          e_err = 1'b1; e_req += TO; lat += TO;
        end else begin
          e_req += al + 1; e_al = 1; lat += al + 2;
          if (vi) e_err = 1'b1;
          else    e_en  = 1;
        end
      end
    end
    lat += 1;
    start = 1'b1;
    for (int c = 0; c < 300 && !resp_seen; c++) tick();
    chk("resp_seen", 32'(resp_seen), 32'd1);
    chk("accept_cycle", acc_at, fl ? fll + 3 : 0);
    chk("resp_latency", resp_at - acc_at, lat);
    chk("resp_err", 32'(resp_err), 32'(e_err));
    chk("mem_req_cycles", n_req, e_req);
    chk("mem_we_cycles", n_we, e_we);
    chk("writeback_pulses", n_wb, e_wb);
    chk("allocate_pulses", n_al, e_al);
    chk("enable_pulses", n_en, e_en);
    if (fl) begin
      chk("flush_cycles", n_fl, fll + 1);
      chk("flush_ack_pulses", n_ack, 1);
      chk("flush_ack_cycle", ack_at, fll + 2);
    end else begin
      chk("no_flush", n_fl + n_ack, 0);
    end
    if (cnt_chk) begin
      chk("hit_count", 32'(bus.hit_count), m_hit);
      chk("miss_count", 32'(bus.miss_count), m_miss);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"},    32'(bus.cpu_req_ready), 32'd1);
    chk({tag, "_resp"},     32'(bus.cpu_resp_valid | bus.cpu_resp_err), 32'd0);
    chk({tag, "_mem"},      32'(bus.mem_req | bus.mem_we), 32'd0);
    chk({tag, "_pulses"},   32'({bus.cache_enable, bus.cache_writeback, bus.cache_allocate,
                                 bus.cache_flush, bus.flush_ack}), 32'd0);
    chk({tag, "_latched"},  32'(bus.cpu_addr) | 32'(bus.cpu_data_in) | 32'(bus.CPU_rd_wr), 32'd0);
    chk({tag, "_hits"},     32'(bus.hit_count), 32'd0);
    chk({tag, "_misses"},   32'(bus.miss_count), 32'd0);
  endtask

  initial begin
    bus.cpu_req_valid = 1'b0; bus.cpu_addr_in = '0; bus.cpu_wdata_in = '0;
    bus.cpu_rd_wr_in  = 1'b0; bus.flush_req = 1'b0; bus.Cache_hit = 1'b0;
    bus.Dirty_bit     = 1'b0; bus.flush_done = 1'b0; bus.mem_ready = 1'b0;
    start = 1'b0; in_mem = 1'b0; cur_we = 1'b0; viol = 1'b0; ph = 0; fc = 0;
    m_hit = 0; m_miss = 0;
    clear_env();
    @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b1;

    // directed: read hit, clean read miss, dirty write miss, timeout, flush priority
    run_txn(DIR_RD, 32'h0000_0010, 32'h0, 1'b1, 1'b0, 0, 0,  1'b0, 0, 1'b0, 1'b1);
    run_txn(DIR_RD, 32'h0000_0020, 32'h0, 1'b0, 1'b0, 0, 2,  1'b0, 0, 1'b0, 1'b1);
    run_txn(DIR_WR, 32'h0000_0030, 32'hDEAD_BEEF, 1'b0, 1'b1, 1, 1, 1'b0, 0, 1'b0, 1'b1);
    run_txn(DIR_RD, 32'h0000_0040, 32'h0, 1'b0, 1'b0, 0, TO + 1, 1'b0, 0, 1'b0, 1'b1);
    run_txn(DIR_WR, 32'h0000_0044, 32'h1234_5678, 1'b0, 1'b1, TO, 0, 1'b0, 0, 1'b0, 1'b1);
    run_txn(DIR_RD, 32'h0000_0048, 32'h0, 1'b0, 1'b0, 0, TO - 1, 1'b0, 0, 1'b0, 1'b1);
    run_txn(DIR_WR, 32'h0000_0050, 32'hCAFE_F00D, 1'b1, 1'b0, 0, 0, 1'b1, 3, 1'b0, 1'b1);

    // random traffic; enough hits and misses to drive both counters into saturation
    for (int i = 0; i < 48; i++)
      run_txn(1'($urandom_range(0, 1)), $urandom, $urandom,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, TO + 1)), int'($urandom_range(0, TO + 1)),
              1'($urandom_range(0, 5) == 0), int'($urandom_range(0, 3)), 1'b0, 1'b1);

    // refill that still misses must complete with an error
    run_txn(DIR_RD, 32'h0000_0060, 32'h0, 1'b0, 1'b0, 0, 1, 1'b0, 0, 1'b1, 1'b0);

    // reset while a write-back is waiting on memory
    clear_env();
    viol = 1'b0; t_fl = 1'b0; t_wr = DIR_WR; t_addr = 32'h0000_0070; t_data = 32'hA5A5_A5A5;
    hit_sel = 1'b0; dirty_sel = 1'b1; wb_lat = TO + 1; al_lat = 0;
    start = 1'b1;
    for (int c = 0; c < 3; c++) tick();
    chk("pre_reset_in_writeback", 32'(bus.mem_req & bus.mem_we), 32'd1);
    #2 rst = 1'b0;
    bus.cpu_req_valid = 1'b0;
    #1;
    chk_reset_outputs("mid_reset");
    @(negedge clk);
    rst = 1'b1;
    clear_env();
    acc_at = 0;
    for (int c = 0; c < 12; c++) tick();
    chk("no_resp_after_reset", 32'(resp_seen), 32'd0);
    chk("no_mem_after_reset", n_req, 0);
    chk("idle_after_reset", 32'(bus.cpu_req_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
